// File: rtl/timer_pkg.sv
// Shared types and constants for the seconds timer.
// Used by the BCD digit chain and its prescaler.
package timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  localparam int unsigned DEFAULT_CLK_FREQ =
    100000000;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit, 0..9, advanced by inc.
// carry_out flags the 9 -> 0 wrap for chaining.
module bcd_digit_counter
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic       carry_out,
  output logic [3:0] value
);

  bcd_digit_t digit;

  // Digit register; wraps 9 -> 0 so A..F are unreachable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (inc) begin
      if (digit == BCD_MAX) begin
        digit <= '0;
      end else begin
        digit <= digit + 4'd1;
      end
    end
  end

  // Carry when this increment wraps the digit.
  always_comb begin
    carry_out = 1'b0;
    if (inc && (digit == BCD_MAX)) begin
      carry_out = 1'b1;
    end
  end

  assign value = digit;

endmodule

// File: rtl/bcd_seconds_counter.sv
// Elapsed-seconds counter 00..99 in packed BCD.
// SECONDS_TICK_OUT_EN exposes the 1 s tick port.
module bcd_seconds_counter
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ =
    DEFAULT_CLK_FREQ
) (
  input  logic       clk,
  input  logic       init_regs,
  input  logic       count_enabled,
  output logic [7:0] time_reading
`ifdef SECONDS_TICK_OUT_EN
  ,
  output logic       one_sec_tick
`endif
);

  localparam int unsigned PW =
    $clog2(CLK_FREQ);

  localparam logic [PW-1:0] PRE_MAX =
    PW'(CLK_FREQ - 1);

  logic [PW-1:0] prescaler;
  logic          tick;
  logic          ones_carry;
  logic          tens_carry_unused;
  logic [3:0]    ones;
  logic [3:0]    tens;

  // Tick marks the enabled cycle at the last prescaler count.
  always_comb begin
    tick = 1'b0;
    if (count_enabled && (prescaler == PRE_MAX)) begin
      tick = 1'b1;
    end
  end

  // Prescaler holds while disabled so no partial second is lost.
  always_ff @(posedge clk or negedge init_regs) begin
    if (!init_regs) begin
      prescaler <= '0;
    end else if (count_enabled) begin
      if (tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  bcd_digit_counter u_ones (
    .clk       (clk),
    .rst_n     (init_regs),
    .inc       (tick),
    .carry_out (ones_carry),
    .value     (ones)
  );

  bcd_digit_counter u_tens (
    .clk       (clk),
    .rst_n     (init_regs),
    .inc       (ones_carry),
    .carry_out (tens_carry_unused),
    .value     (tens)
  );

  assign time_reading = {tens, ones};

`ifdef SECONDS_TICK_OUT_EN
  assign one_sec_tick = tick;
`endif

endmodule

// File: tb/tb_bcd_seconds_counter.sv
// Directed bench for bcd_seconds_counter.
// Main DUT at CLK_FREQ=10, second at CLK_FREQ=1000.
module tb_bcd_seconds_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] tr;
  logic       rst2_n;
  logic       en2;
  logic [7:0] tr2;
`ifdef SECONDS_TICK_OUT_EN
  logic       tick;
  logic       tick2;
`endif

  int pass_cnt;
  int total_cnt;

  bcd_seconds_counter #(
    .CLK_FREQ (10)
  ) dut (
    .clk           (clk),
    .init_regs     (rst_n),
    .count_enabled (en),
    .time_reading  (tr)
`ifdef SECONDS_TICK_OUT_EN
    ,
    .one_sec_tick  (tick)
`endif
  );

  bcd_seconds_counter #(
    .CLK_FREQ (1000)
  ) dut2 (
    .clk           (clk),
    .init_regs     (rst2_n),
    .count_enabled (en2),
    .time_reading  (tr2)
`ifdef SECONDS_TICK_OUT_EN
    ,
    .one_sec_tick  (tick2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         edges;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm,
                         input int act,
                         input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic run_count(input int n,
                           output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
`ifdef SECONDS_TICK_OUT_EN
      if (tick === 1'b1) pulses++;
`endif
    end
  endtask

  initial begin
    int p;
    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0]  = '{"pre_first", 9, 1'b1, 8'h00};
    vecs[1]  = '{"first_sec", 1, 1'b1, 8'h01};
    vecs[2]  = '{"second_sec", 10, 1'b1, 8'h02};
    vecs[3]  = '{"nine_sec", 70, 1'b1, 8'h09};
    vecs[4]  = '{"carry_10", 10, 1'b1, 8'h10};
    vecs[5]  = '{"pre4", 4, 1'b1, 8'h10};
    vecs[6]  = '{"hold37", 37, 1'b0, 8'h10};
    vecs[7]  = '{"resume5", 5, 1'b1, 8'h10};
    vecs[8]  = '{"resume6", 1, 1'b1, 8'h11};
    vecs[9]  = '{"reach99", 880, 1'b1, 8'h99};
    vecs[10] = '{"wrap00", 10, 1'b1, 8'h00};

    rst_n  = 1'b0;
    en     = 1'b1;
    rst2_n = 1'b0;
    en2    = 1'b1;
    step(2);
    chk("reset_val", tr, 8'h00);
`ifdef SECONDS_TICK_OUT_EN
    chk("reset_tick", {7'd0, tick}, 8'h00);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      en = vecs[i].en;
      step(vecs[i].edges);
      chk(vecs[i].name, tr, vecs[i].exp);
    end

    en = 1'b1;
    step(570);
    chk("at57", tr, 8'h57);
    step(3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", tr, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_hold", tr, 8'h00);
    rst_n = 1'b1;
    step(9);
    chk("restart9", tr, 8'h00);
    step(1);
    chk("restart10", tr, 8'h01);

    run_count(20, p);
    chk("run20", tr, 8'h03);
`ifdef SECONDS_TICK_OUT_EN
    chk_int("tick_pulses", p, 2);
`endif
    step(9);
    en = 1'b0;
    run_count(15, p);
    chk("held_p9", tr, 8'h03);
`ifdef SECONDS_TICK_OUT_EN
    chk_int("tick_disabled", p, 0);
`endif
    en = 1'b1;
    #1;
`ifdef SECONDS_TICK_OUT_EN
    chk("tick_reen", {7'd0, tick}, 8'h01);
`endif
    step(1);
    chk("reen_inc", tr, 8'h04);
    chk_int("no_ab_hi", int'(tr[7:4] > 4'd9), 0);

    chk("d2_reset", tr2, 8'h00);
    rst2_n = 1'b1;
    step(999);
    chk("d2_pre1s", tr2, 8'h00);
    step(1);
    chk("d2_1s", tr2, 8'h01);
    step(1000);
    chk("d2_2s", tr2, 8'h02);

    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

endmodule
